instruction_fetch_queue: RTL and testbench

Parametrised next-generation fetch stage for the MIPS pipeline. It drives an external synchronous instruction memory through an address/enable port and buffers the returned words in a QUEUE_DEPTH-entry prefetch queue. It presents {instruction, pc+4} to decode over a valid/ready handshake. Control-flow redirects (branch, J/JAL, JR/JALR) flush all buffered and in-flight fetches.

---
 rtl/instruction_fetch_queue_pkg.sv | 32 +++
 rtl/instruction_fetch_queue_fifo.sv | 49 ++++
 rtl/instruction_fetch_queue.sv | 118 +++++++++++
 tb/tb_instruction_fetch_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: field widths, the NOP
// encoding, redirect kinds and a ceiling-log2 helper.
package instruction_fetch_queue_pkg;

   localparam int NB_ADDR_DEF  = 32;
   localparam int NB_INSTR_DEF = 32;
   localparam int NB_INM_I_DEF = 16;
   localparam int NB_INM_J_DEF = 26;

   localparam logic [NB_INSTR_DEF-1:0] NOP_INSTR_DEF = 32'h0000_0000;

   // Ordered by priority: a register jump beats an immediate jump beats a branch
   typedef enum logic [1:0] {
      REDIR_NONE     = 2'd0,
      REDIR_BRANCH   = 2'd1,
      REDIR_JUMP_INM = 2'd2,
      REDIR_JUMP_RS  = 2'd3
   } redirect_kind_e;

   function automatic int clogb2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/instruction_fetch_queue_fifo.sv
// Power-of-two FIFO holding prefetched {instruction, pc+4} entries.
// Flush empties it in one cycle and wins over a simultaneous push.
module fetch_queue_fifo
   import instruction_fetch_queue_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           head_data,
   output logic [clogb2(DEPTH):0]     count
);

   localparam int PW = clogb2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             pop_ok;

   assign pop_ok    = pop & (count != '0);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset | flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push & ~flush & ~reset) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: issues word reads to a 1-cycle synchronous instruction memory,
// queues the returned words and hands {instr, pc+4} to decode over valid/ready.
module instruction_fetch_queue
   import instruction_fetch_queue_pkg::*;
#(
   parameter int                    NB_ADDR     = NB_ADDR_DEF,
   parameter int                    NB_INSTR    = NB_INSTR_DEF,
   parameter int                    NB_INM_I    = NB_INM_I_DEF,
   parameter int                    NB_INM_J    = NB_INM_J_DEF,
   parameter int                    QUEUE_DEPTH = 4,
   parameter logic [NB_ADDR-1:0]    RESET_PC    = '0,
   parameter logic [NB_INSTR-1:0]   NOP_INSTR   = NOP_INSTR_DEF
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_enable,
   output logic [NB_ADDR-1:0]    o_imem_addr,
   output logic                  o_imem_en,
   input  logic [NB_INSTR-1:0]   i_imem_data,
   output logic [NB_INSTR-1:0]   o_instr,
   output logic [NB_ADDR-1:0]    o_pc,
   output logic                  o_valid,
   input  logic                  i_ready,
   input  logic [NB_ADDR-1:0]    i_redirect_pc,
   input  logic [NB_INM_I-1:0]   i_inm_i,
   input  logic [NB_INM_J-1:0]   i_inm_j,
   input  logic [NB_ADDR-1:0]    i_rs,
   input  logic                  i_branch,
   input  logic                  i_jump_inm,
   input  logic                  i_jump_rs
);

   // Handshake: decode takes the head on a clock edge where o_valid and
   // i_ready are both high; o_valid never depends on i_ready.

   localparam int CW = clogb2(QUEUE_DEPTH) + 1;
   localparam int EW = NB_INSTR + NB_ADDR;

   logic [NB_ADDR-1:0] pc;
   logic [NB_ADDR-1:0] issued_addr;
   logic [NB_ADDR-1:0] target;
   logic [NB_ADDR-1:0] branch_offset;
   logic               inflight;
   redirect_kind_e     redirect_kind;
   logic               redirect;
   logic               deq;
   logic               issue;
   logic               push;
   logic [CW-1:0]      count;
   logic [CW:0]        occupancy;
   logic [EW-1:0]      head_data;
   logic [EW-1:0]      push_data;

   always_comb begin
      redirect_kind = REDIR_NONE;
      if (i_jump_rs)       redirect_kind = REDIR_JUMP_RS;
      else if (i_jump_inm) redirect_kind = REDIR_JUMP_INM;
      else if (i_branch)   redirect_kind = REDIR_BRANCH;
   end

   assign redirect      = (redirect_kind != REDIR_NONE);
   assign branch_offset = {{(NB_ADDR-NB_INM_I-2){i_inm_i[NB_INM_I-1]}}, i_inm_i, 2'b00};

   always_comb begin
      target = pc;
      case (redirect_kind)
         REDIR_JUMP_RS:  target = i_rs;
         REDIR_JUMP_INM: target = {i_redirect_pc[NB_ADDR-1 -: 4], i_inm_j, 2'b00};
         REDIR_BRANCH:   target = i_redirect_pc + branch_offset;
         default:        target = pc;
      endcase
   end

   // Counting the in-flight word as occupied guarantees room for its return
   assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq);
   assign o_valid   = (count != '0) & i_enable & ~redirect & ~i_reset;
   assign deq       = o_valid & i_ready;
   assign issue     = i_enable & ~redirect & ~i_reset & (occupancy < (CW+1)'(QUEUE_DEPTH));
   assign push      = inflight & ~redirect;
   assign push_data = {i_imem_data, issued_addr + NB_ADDR'(4)};

   assign o_imem_en   = issue;
   assign o_imem_addr = pc;
   assign o_instr     = o_valid ? head_data[EW-1 -: NB_INSTR] : NOP_INSTR;
   assign o_pc        = o_valid ? head_data[NB_ADDR-1:0] : '0;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         pc          <= RESET_PC;
         issued_addr <= RESET_PC;
         inflight    <= 1'b0;
      end else if (redirect) begin
         pc       <= target;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc          <= pc + NB_ADDR'(4);
            issued_addr <= pc;
         end
      end
   end

   fetch_queue_fifo #(
      .WIDTH (EW),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clock     (i_clock),
      .reset     (i_reset),
      .push      (push),
      .pop       (deq),
      .flush     (redirect),
      .push_data (push_data),
      .head_data (head_data),
      .count     (count)
   );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: cycle table with hand-computed
// outputs, then reset-mid-stream and a randomly stalled in-order stream.
module tb_instruction_fetch_queue;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [31:0] imem_addr;
   logic        imem_en;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        valid;
   logic        ready;
   logic [31:0] redirect_pc;
   logic [15:0] inm_i;
   logic [25:0] inm_j;
   logic [31:0] rs;
   logic        branch;
   logic        jump_inm;
   logic        jump_rs;

   int n_checks = 0;
   int n_fail   = 0;

   instruction_fetch_queue dut (
      .i_clock       (clock),
      .i_reset       (reset),
      .i_enable      (enable),
      .o_imem_addr   (imem_addr),
      .o_imem_en     (imem_en),
      .i_imem_data   (imem_data),
      .o_instr       (instr),
      .o_pc          (pc),
      .o_valid       (valid),
      .i_ready       (ready),
      .i_redirect_pc (redirect_pc),
      .i_inm_i       (inm_i),
      .i_inm_j       (inm_j),
      .i_rs          (rs),
      .i_branch      (branch),
      .i_jump_inm    (jump_inm),
      .i_jump_rs     (jump_rs)
   );

   // clock / reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction memory model: mem[a] = a, one cycle read latency
   initial imem_data = '0;
   always @(posedge clock) if (imem_en) imem_data <= imem_addr;

   typedef struct {
      logic        en;
      logic        rdy;
      logic        br;
      logic        ji;
      logic        jr;
      logic [31:0] rpc;
      logic [15:0] ii;
      logic [25:0] ij;
      logic [31:0] rs;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic        exp_en;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[$];
   logic [31:0] exp_q[$];

   task automatic add_v(input logic en, input logic rdy, input logic br, input logic ji,
                        input logic jr, input logic [31:0] rpc, input logic [15:0] ii,
                        input logic [25:0] ij, input logic [31:0] r, input logic ev,
                        input logic [31:0] epc, input logic een, input logic [31:0] ea);
      vec_t v;
      v.en = en; v.rdy = rdy; v.br = br; v.ji = ji; v.jr = jr;
      v.rpc = rpc; v.ii = ii; v.ij = ij; v.rs = r;
      v.exp_valid = ev; v.exp_pc = epc; v.exp_en = een; v.exp_addr = ea;
      vecs.push_back(v);
   endtask

   // plain running cycle: enabled, optional stall, no redirect
   task automatic add_run(input logic rdy, input logic ev, input logic [31:0] epc,
                          input logic een, input logic [31:0] ea);
      add_v(1'b1, rdy, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, ev, epc, een, ea);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      enable = 1'b1; ready = 1'b1; branch = 1'b0; jump_inm = 1'b0; jump_rs = 1'b0;
      redirect_pc = '0; inm_i = '0; inm_j = '0; rs = '0;
   endtask

   task automatic check_outputs(input string tag, input logic ev, input logic [31:0] epc,
                                input logic een, input logic [31:0] ea);
      check({tag, " valid"}, {31'b0, valid}, {31'b0, ev});
      check({tag, " pc"}, pc, ev ? epc : 32'h0);
      check({tag, " instr"}, instr, ev ? epc - 32'd4 : 32'h0);
      check({tag, " imem_en"}, {31'b0, imem_en}, {31'b0, een});
      check({tag, " imem_addr"}, imem_addr, ea);
   endtask

   initial begin
      // table: cycle numbers count from the first cycle after reset release
      add_run(1, 0, 0, 1, 32'h0);
      add_run(1, 0, 0, 1, 32'h4);
      add_run(1, 1, 32'h4, 1, 32'h8);
      add_run(1, 1, 32'h8, 1, 32'hC);
      add_run(1, 1, 32'hC, 1, 32'h10);
      add_v(1, 1, 1, 0, 0, 32'h20, 16'hFFFE, '0, '0, 0, 0, 0, 32'h14);
      add_run(1, 0, 0, 1, 32'h18);
      add_run(1, 0, 0, 1, 32'h1C);
      add_run(1, 1, 32'h1C, 1, 32'h20);
      add_run(1, 1, 32'h20, 1, 32'h24);
      add_v(1, 1, 0, 1, 0, 32'h4000_0010, '0, 26'h40, '0, 0, 0, 0, 32'h28);
      add_run(1, 0, 0, 1, 32'h4000_0100);
      add_run(1, 0, 0, 1, 32'h4000_0104);
      add_run(1, 1, 32'h4000_0104, 1, 32'h4000_0108);
      add_v(1, 1, 1, 1, 1, 32'h20, 16'h1, 26'h1, 32'h80, 0, 0, 0, 32'h4000_010C);
      add_run(1, 0, 0, 1, 32'h80);
      add_run(1, 0, 0, 1, 32'h84);
      add_run(1, 1, 32'h84, 1, 32'h88);
      add_run(1, 1, 32'h88, 1, 32'h8C);
      // ten stalled cycles: queue fills to four, issue stops
      add_run(0, 1, 32'h8C, 1, 32'h90);
      add_run(0, 1, 32'h8C, 1, 32'h94);
      for (int i = 0; i < 8; i++) add_run(0, 1, 32'h8C, 0, 32'h98);
      add_run(1, 1, 32'h8C, 1, 32'h98);
      add_run(1, 1, 32'h90, 1, 32'h9C);
      add_run(1, 1, 32'h94, 1, 32'hA0);
      add_run(1, 1, 32'h98, 1, 32'hA4);
      add_run(1, 1, 32'h9C, 1, 32'hA8);
      add_run(1, 1, 32'hA0, 1, 32'hAC);
      // five disabled cycles: in-flight word is still captured
      for (int i = 0; i < 5; i++)
         add_v(0, 1, 0, 0, 0, '0, '0, '0, '0, 0, 0, 0, 32'hB0);
      add_run(1, 1, 32'hA4, 1, 32'hB0);
      add_run(1, 1, 32'hA8, 1, 32'hB4);
      add_run(1, 1, 32'hAC, 1, 32'hB8);
      add_run(1, 1, 32'hB0, 1, 32'hBC);
      add_run(1, 1, 32'hB4, 1, 32'hC0);

      drive_idle();
      enable = 1'b0;
      reset  = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #4 check_outputs("reset", 0, 0, 0, 32'h0);
      @(posedge clock); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         enable = vecs[i].en; ready = vecs[i].rdy;
         branch = vecs[i].br; jump_inm = vecs[i].ji; jump_rs = vecs[i].jr;
         redirect_pc = vecs[i].rpc; inm_i = vecs[i].ii; inm_j = vecs[i].ij; rs = vecs[i].rs;
         #4 check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                          vecs[i].exp_en, vecs[i].exp_addr);
         @(posedge clock); #1;
      end

      // reset mid-stream with a word in flight
      drive_idle();
      reset = 1'b1;
      #4 check_outputs("in_reset", 0, 0, 0, 32'hC4);
      @(posedge clock); #1;
      reset = 1'b0;
      #4 check_outputs("post_reset0", 0, 0, 1, 32'h0);
      @(posedge clock); #1;
      #4 check_outputs("post_reset1", 0, 0, 1, 32'h4);
      @(posedge clock); #1;
      #4 check_outputs("post_reset2", 1, 32'h4, 1, 32'h8);
      @(posedge clock); #1;

      // randomly stalled stream: every accepted word is the next in order
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 1; i <= 300; i++) exp_q.push_back(32'(4 * i));
      begin
         int accepted;
         logic [31:0] exp;
         accepted = 0;
         for (int cyc = 0; cyc < 300; cyc++) begin
            ready  = ($urandom_range(0, 2) != 0);
            enable = ($urandom_range(0, 4) != 0);
            #4;
            if (valid && ready) begin
               exp = exp_q.pop_front();
               check("stream pc", pc, exp);
               check("stream instr", instr, exp - 32'd4);
               accepted++;
            end
            @(posedge clock); #1;
         end
         check("stream progress", {31'b0, accepted >= 60}, 32'h1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
